// File: rtl/wb_trace_buffer_pkg.sv
// Shared CPU trace package: layout of one writeback trace entry.
// Trace consumers import this package to decode the 69-bit entry
// {PC, destination register, write data}, PC in the upper bits.
package wb_trace_buffer_pkg;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_RD_W   = 5;
  localparam int TRACE_DATA_W = 32;

  localparam int TRACE_DATA_LSB = 0;
  localparam int TRACE_RD_LSB   = TRACE_DATA_LSB + TRACE_DATA_W;
  localparam int TRACE_PC_LSB   = TRACE_RD_LSB + TRACE_RD_W;
  localparam int TRACE_ENTRY_W  = TRACE_PC_LSB + TRACE_PC_W;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_RD_W-1:0]   regDest;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_if.sv
// Writeback trace bundle: capture-side inputs from the writeback stage,
// head-of-FIFO trace outputs with a valid/ready handshake, and status.
//   master : writeback stage + trace consumer (drives capture, Ready)
//   slave  : the trace buffer
interface wb_trace_if #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);
  import wb_trace_buffer_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                    RegWrite_In;
  logic [TRACE_RD_W-1:0]   RegDest_In;
  logic [TRACE_DATA_W-1:0] WriteData_In;
  logic [TRACE_PC_W-1:0]   PC_In;
  logic                    Freeze;

  logic                    Trace_Valid;
  logic                    Trace_Ready;
  logic [TRACE_PC_W-1:0]   Trace_PC;
  logic [TRACE_RD_W-1:0]   Trace_RegDest;
  logic [TRACE_DATA_W-1:0] Trace_Data;

  logic [CNT_W-1:0]        Count;
  logic                    Overflow;
  logic [DROP_W-1:0]       DropCount;

  modport master (
    output RegWrite_In, RegDest_In, WriteData_In, PC_In, Freeze, Trace_Ready,
    input  Trace_Valid, Trace_PC, Trace_RegDest, Trace_Data,
    input  Count, Overflow, DropCount
  );

  modport slave (
    input  RegWrite_In, RegDest_In, WriteData_In, PC_In, Freeze, Trace_Ready,
    output Trace_Valid, Trace_PC, Trace_RegDest, Trace_Data,
    output Count, Overflow, DropCount
  );

endinterface

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: DEPTH x WIDTH array, one synchronous write port
// and one asynchronous (combinational) read port. No reset on contents.
//   Clock  : write clock, rising edge
//   wrEn   : write enable
//   wrAddr : write address
//   wrData : write entry
//   rdAddr : read address
//   rdData : entry at rdAddr, combinational
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 69
) (
  input  logic                     Clock,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [WIDTH-1:0]         rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures every architectural register write
// ({PC, rd, data}) into a FIFO and presents the oldest entry on a
// valid/ready port. Writes to $0 and writes while frozen are ignored.
// A capture into a full buffer with no simultaneous pop is dropped and
// recorded in the sticky Overflow flag and a saturating DropCount.
//   Clock : rising-edge clock
//   Reset : asynchronous active-low reset
//   tr    : capture inputs, trace head outputs, Count/Overflow/DropCount
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic    Clock,
  input  logic    Reset,
  wb_trace_if.slave tr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DROP_W-1:0] dropCount;

  logic              capture;
  logic              full;
  logic              empty;
  logic              doPush;
  logic              doPop;
  logic              doDrop;
  trace_entry_t      wrEntry;
  trace_entry_t      headEntry;

  function automatic logic [DROP_W-1:0] satInc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Full/empty come from the occupancy counter, so the pointers can be
  // plain modulo-DEPTH indices without an extra wrap bit.
  always_comb begin
    capture = tr.RegWrite_In && (tr.RegDest_In != '0) && !tr.Freeze;
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    doPop   = !empty && tr.Trace_Ready;
    // A pop on the same edge frees the slot the push needs.
    doPush  = capture && (!full || doPop);
    doDrop  = capture && full && !doPop;

    wrEntry.pc      = tr.PC_In;
    wrEntry.regDest = tr.RegDest_In;
    wrEntry.data    = tr.WriteData_In;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      dropCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (doDrop) begin
        overflow  <= 1'b1;
        dropCount <= satInc(dropCount);
      end
    end
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_ENTRY_W)
  ) u_mem (
    .Clock  (Clock),
    .wrEn   (doPush),
    .wrAddr (wrPtr),
    .wrData (wrEntry),
    .rdAddr (rdPtr),
    .rdData (headEntry)
  );

  assign tr.Trace_Valid   = !empty;
  assign tr.Trace_PC      = headEntry.pc;
  assign tr.Trace_RegDest = headEntry.regDest;
  assign tr.Trace_Data    = headEntry.data;
  assign tr.Count         = count;
  assign tr.Overflow      = overflow;
  assign tr.DropCount     = dropCount;

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, 2..256.
REQ-002 SHALL have parameter DROP_W, default 16, width of the dropped-write counter.
REQ-003 SHALL have port Clock, input, 1, the single clock, rising-edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port RegWrite_In, input, 1, writeback-stage register-write enable.
REQ-006 SHALL have port RegDest_In, input, 5, writeback destination register.
REQ-007 SHALL have port WriteData_In, input, 32, writeback data (post MemToReg mux).
REQ-008 SHALL have port PC_In, input, 32, PC of the writing instruction.
REQ-009 SHALL have port Freeze, input, 1, when 1 suppresses all capture.
REQ-010 SHALL have port Trace_Valid, output, 1, the head entry is presented.
REQ-011 SHALL have port Trace_Ready, input, 1, the consumer accepts the head entry.
REQ-012 SHALL have port Trace_PC, output, 32, PC of the head entry.
REQ-013 SHALL have port Trace_RegDest, output, 5, destination of the head entry.
REQ-014 SHALL have port Trace_Data, output, 32, write data of the head entry.
REQ-015 SHALL have port Count, output, log2(DEPTH)+1, current occupancy.
REQ-016 SHALL have port Overflow, output, 1, sticky flag set when any write is dropped.
REQ-017 SHALL have port DropCount, output, DROP_W, count of dropped writes, saturating.

Function
REQ-018 Capture event SHALL be RegWrite_In=1 and RegDest_In!=0 and Freeze=0, sampled each rising edge.
REQ-019 Each capture SHALL push one {PC_In, RegDest_In, WriteData_In} entry; order SHALL be preserved (FIFO).
REQ-020 Pop SHALL occur on a rising edge with Trace_Valid=1 and Trace_Ready=1.
REQ-021 Trace_Valid SHALL equal (Count!=0); Trace_* SHALL show the head entry combinationally from storage and hold stable while Valid=1 and Ready=0.
REQ-022 Push-to-Valid latency SHALL be 1 cycle: a capture into an empty buffer raises Trace_Valid after that edge.
REQ-023 Count SHALL update the edge after a push or pop: +1 push only, -1 pop only, unchanged for both or neither.
REQ-024 When full, a capture in the same cycle as a pop SHALL be accepted; Count remains DEPTH.
REQ-025 When full without a pop, a capture SHALL be dropped: contents unchanged, Overflow<=1, DropCount+1 saturating at all-ones.
REQ-026 When empty, Trace_Ready SHALL be ignored and no pop occurs; push and Ready in the same cycle SHALL NOT bypass the entry.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be decided from Count.
REQ-028 Overflow and DropCount SHALL clear only by reset.
REQ-029 Freeze SHALL NOT block pops; drains continue while frozen.

Reset
REQ-030 Reset=0 SHALL asynchronously set pointers=0, Count=0, Trace_Valid=0, Overflow=0, DropCount=0.
REQ-031 Entry storage SHALL NOT require reset; Trace_PC/RegDest/Data are don't-care while Trace_Valid=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; the first capture after deassertion SHALL be the first entry presented.
REQ-033 No push or pop SHALL occur on an edge where Reset=0.

Structure
REQ-034 Entry layout (field widths, bit offsets, 69-bit entry width) SHALL be constants in the shared CPU package, reused by trace consumers.
REQ-035 Storage SHALL be a sub-module trace_fifo_mem (DEPTH x 69, one synchronous write port, one asynchronous read port); capture, pointer, count and overflow logic SHALL stay in wb_trace_buffer.

Verification
REQ-036 Reset, then capture 3 writes (PC 0x0,0x4,0x8, $2 data 1,2,3) with Ready=0 -> Count=3, head PC=0x0; Ready=1 for 3 cycles -> entries emitted in order, Count=0, Valid=0.
REQ-037 RegWrite_In=1 with RegDest_In=0, and a capture with Freeze=1 -> no push, Count unchanged.
REQ-038 DEPTH=16, 20 captures with Ready=0 -> Count=16, Overflow=1, DropCount=4; drained entries are the first 16 in order.
REQ-039 Full buffer, capture and pop on the same edge -> Count stays 16, new entry is last out, DropCount unchanged.
REQ-040 DROP_W=4, 20 drops -> DropCount saturates at 15.
REQ-041 Reset asserted with Count=5 -> Valid=0 immediately; after release, 1 capture -> Valid next cycle with that entry, Count=1.
